// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared refill types and line geometry for the cache controller and refill engine
package cache_pkg;

   localparam int CACHE_ADDR_W = 32;
   localparam int BEAT_BYTES   = 8;
   localparam int BEAT_SHIFT   = $clog2(BEAT_BYTES);
   localparam int LINE_BYTES   = BEAT_BYTES * 4;
   localparam int OFFSET_W     = $clog2(LINE_BYTES);

   typedef logic [CACHE_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } refill_state_t;

endpackage

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - single-miss line refill sequencer: issues per-beat Pmem reads,
// assembles the line, flags per-beat timeouts and hands the line to the data array.
module cache_refill_engine
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int BEAT_W     = 64,
   parameter int LINE_BEATS = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_req_valid,
   output logic                         miss_req_ready,
   input  logic [ADDR_W-1:0]            miss_req_addr,
   output logic                         mem_rd_en,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic [BEAT_W-1:0]            mem_data,
   input  logic                         mem_data_valid,
   output logic                         fill_valid,
   input  logic                         fill_ready,
   output logic [ADDR_W-1:0]            fill_addr,
   output logic [BEAT_W*LINE_BEATS-1:0] fill_line,
   output logic                         fill_err,
   output logic                         busy
);

   localparam int LINE_W       = BEAT_W * LINE_BEATS;
   localparam int BEAT_CNT_W   = $clog2(LINE_BEATS);
   localparam int TMO_W        = $clog2(TIMEOUT);
   localparam int LINE_BYTES_P = BEAT_BYTES * LINE_BEATS;
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES_P - 1);

   refill_state_t         state_q, state_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [BEAT_CNT_W-1:0] beat_q, beat_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic                  err_q, err_d;
   logic                  last_beat;
   logic                  tmo_hit;

   assign last_beat = (beat_q == BEAT_CNT_W'(LINE_BEATS - 1));
   assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (miss_req_valid) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT: begin
            if (mem_data_valid) state_d = last_beat ? RESP : ISSUE;
            else if (tmo_hit)   state_d = RESP;
         end
         RESP:    if (fill_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= '0;
         beat_q <= '0;
         tmo_q  <= '0;
         line_q <= '0;
         err_q  <= 1'b0;
      end else begin
         base_q <= base_d;
         beat_q <= beat_d;
         tmo_q  <= tmo_d;
         line_q <= line_d;
         err_q  <= err_d;
      end
   end

   // Beats not returned before a timeout stay zero because the buffer is cleared on accept.
   always_comb begin
      base_d = base_q;
      beat_d = beat_q;
      tmo_d  = tmo_q;
      line_d = line_q;
      err_d  = err_q;
      unique case (state_q)
         IDLE: begin
            if (miss_req_valid) begin
               base_d = miss_req_addr & ~OFFSET_MASK;
               beat_d = '0;
               line_d = '0;
               err_d  = 1'b0;
            end
         end
         ISSUE: tmo_d = '0;
         WAIT: begin
            if (mem_data_valid) begin
               line_d[BEAT_W*beat_q +: BEAT_W] = mem_data;
               if (!last_beat) beat_d = beat_q + BEAT_CNT_W'(1);
            end else if (tmo_hit) begin
               err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: ;
      endcase
   end

   // The beat counter only moves in WAIT, so mem_addr holds between strobes.
   always_comb begin
      miss_req_ready = (state_q == IDLE);
      mem_rd_en      = (state_q == ISSUE);
      mem_addr       = base_q + ADDR_W'({beat_q, {BEAT_SHIFT{1'b0}}});
      fill_valid     = (state_q == RESP);
      fill_addr      = base_q;
      fill_line      = line_q;
      fill_err       = err_q && (state_q == RESP);
      busy           = (state_q != IDLE);
   end

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - directed, table-driven bench for cache_refill_engine
module tb_cache_refill_engine;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         miss_req_valid = 1'b0;
   logic         miss_req_ready;
   logic [31:0]  miss_req_addr = '0;
   logic         mem_rd_en;
   logic [31:0]  mem_addr;
   logic [63:0]  mem_data = '0;
   logic         mem_data_valid = 1'b0;
   logic         fill_valid;
   logic         fill_ready = 1'b0;
   logic [31:0]  fill_addr;
   logic [255:0] fill_line;
   logic         fill_err;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_refill_engine dut (
      .clk            (clk),
      .rst            (rst),
      .miss_req_valid (miss_req_valid),
      .miss_req_ready (miss_req_ready),
      .miss_req_addr  (miss_req_addr),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .fill_valid     (fill_valid),
      .fill_ready     (fill_ready),
      .fill_addr      (fill_addr),
      .fill_line      (fill_line),
      .fill_err       (fill_err),
      .busy           (busy)
   );

   typedef struct {
      logic [31:0]  addr;
      logic [63:0]  seed;
      int           silent;
      bit           spur;
      int           stall;
      logic [31:0]  exp_addr;
      logic [255:0] exp_line;
      logic         exp_err;
      int           exp_lat;
      int           exp_rd;
   } vec_t;

   vec_t vecs[5];
   vec_t vw;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [63:0] seed, input int silent,
                               input bit spur, input int stall, input logic [31:0] exp_addr,
                               input logic [255:0] exp_line, input logic exp_err,
                               input int exp_lat, input int exp_rd);
      vec_t v;
      v.addr = addr; v.seed = seed; v.silent = silent; v.spur = spur; v.stall = stall;
      v.exp_addr = exp_addr; v.exp_line = exp_line; v.exp_err = exp_err;
      v.exp_lat = exp_lat; v.exp_rd = exp_rd;
      return v;
   endfunction

   // Starts and ends just after a negedge; leaves the engine in its first ISSUE cycle.
   task automatic req(input logic [31:0] addr);
      chk("req_ready", miss_req_ready, 1'b1);
      miss_req_valid = 1'b1;
      miss_req_addr  = addr;
      @(negedge clk);
      miss_req_valid = 1'b0;
   endtask

   // Pmem model: answers one cycle after each strobe unless the beat is the silent one.
   task automatic serve(input vec_t v);
      int  n, rd, bidx;
      bit  pend, done;
      n = 1; rd = 0; bidx = 0; pend = 0; done = 0;
      while (!done && n <= 60) begin
         mem_data_valid = 1'b0;
         if (fill_valid) begin
            done = 1;
         end else begin
            if (pend) begin
               pend = 0;
               if (bidx != v.silent) begin
                  mem_data_valid = 1'b1;
                  mem_data       = v.seed * 64'(bidx + 1);
               end
            end
            if (mem_rd_en) begin
               chk("mem_addr", mem_addr, v.exp_addr + 32'(8 * rd));
               bidx = rd;
               rd++;
               pend = 1;
               if (v.spur) begin
                  mem_data_valid = 1'b1;
                  mem_data       = 64'hBAD0_BAD0_BAD0_BAD0;
               end
            end
            @(negedge clk);
            n++;
         end
      end
      chk("latency", 32'(n), 32'(v.exp_lat));
      chk("fill_addr", fill_addr, v.exp_addr);
      chk("fill_line", fill_line, v.exp_line);
      chk("fill_err", fill_err, v.exp_err);
      chk("rd_pulses", 32'(rd), 32'(v.exp_rd));
      chk("resp_ready", miss_req_ready, 1'b0);
      chk("resp_busy", busy, 1'b1);
   endtask

   task automatic handshake(input vec_t v);
      for (int s = 0; s < v.stall; s++) begin
         @(negedge clk);
         chk("stall_valid", fill_valid, 1'b1);
         chk("stall_line", fill_line, v.exp_line);
         chk("stall_err", fill_err, v.exp_err);
      end
      fill_ready = 1'b1;
      @(negedge clk);
      fill_ready = 1'b0;
      chk("post_valid", fill_valid, 1'b0);
      chk("post_ready", miss_req_ready, 1'b1);
      chk("post_busy", busy, 1'b0);
      chk("post_err", fill_err, 1'b0);
   endtask

   initial begin
      vecs[0] = mk(32'h0000_1234, 64'h1111_1111_1111_1111, 4, 1'b0, 0, 32'h0000_1220,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 9, 4);
      vecs[1] = mk(32'hABCD_EF1F, 64'h0102_0304_0506_0708, 4, 1'b1, 3, 32'hABCD_EF00,
                   {64'h0408_0C10_1418_1C20, 64'h0306_090C_0F12_1518,
                    64'h0204_0608_0A0C_0E10, 64'h0102_0304_0506_0708}, 1'b0, 9, 4);
      vecs[2] = mk(32'h8000_0047, 64'hDEAD_BEEF_0000_0001, 2, 1'b0, 2, 32'h8000_0040,
                   {64'h0, 64'h0, 64'hBD5B_7DDE_0000_0002, 64'hDEAD_BEEF_0000_0001},
                   1'b1, 22, 3);
      vecs[3] = mk(32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b0, 0, 32'h0000_0000,
                   {64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFD,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 9, 4);
      vecs[4] = mk(32'h0000_011F, 64'h5, 0, 1'b0, 0, 32'h0000_0100, 256'h0, 1'b1, 18, 1);
      vw = vecs[0];
      vw.addr     = 32'hFFFF_FFE8;
      vw.exp_addr = 32'hFFFF_FFE0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", miss_req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_fill_valid", fill_valid, 1'b0);
      chk("rst_fill_err", fill_err, 1'b0);
      chk("rst_fill_addr", fill_addr, 32'h0);
      chk("rst_fill_line", fill_line, 256'h0);

      for (int i = 0; i < 5; i++) begin
         req(vecs[i].addr);
         serve(vecs[i]);
         handshake(vecs[i]);
         if (i == 0) begin
            // stray Pmem data while idle must not disturb the held line
            for (int k = 0; k < 2; k++) begin
               mem_data_valid = 1'b1;
               mem_data       = 64'hDEAD_0000_0000_BEEF;
               @(negedge clk);
               chk("idle_spur_busy", busy, 1'b0);
               chk("idle_spur_line", fill_line, vecs[0].exp_line);
            end
            mem_data_valid = 1'b0;
         end
      end

      // request held while the fill is stalled; accepted right after the handshake
      req(vecs[0].addr);
      serve(vecs[0]);
      miss_req_valid = 1'b1;
      miss_req_addr  = vecs[3].addr;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("hold_valid", fill_valid, 1'b1);
         chk("hold_line", fill_line, vecs[0].exp_line);
         chk("hold_addr", fill_addr, vecs[0].exp_addr);
         chk("hold_ready", miss_req_ready, 1'b0);
      end
      fill_ready = 1'b1;
      @(negedge clk);
      fill_ready = 1'b0;
      chk("b2b_ready", miss_req_ready, 1'b1);
      chk("b2b_fill_valid", fill_valid, 1'b0);
      @(negedge clk);
      miss_req_valid = 1'b0;
      chk("b2b_busy", busy, 1'b1);
      serve(vecs[3]);
      handshake(vecs[3]);

      // reset during the WAIT of beat 1
      req(vecs[0].addr);
      chk("abort_rd0", mem_rd_en, 1'b1);
      @(negedge clk);
      mem_data_valid = 1'b1;
      mem_data       = 64'h1111_1111_1111_1111;
      @(negedge clk);
      mem_data_valid = 1'b0;
      chk("abort_rd1", mem_rd_en, 1'b1);
      chk("abort_addr1", mem_addr, 32'h0000_1228);
      @(negedge clk);
      chk("abort_wait_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_data_valid = 1'b1;
      mem_data       = 64'h2222_2222_2222_2222;
      chk("abort_busy", busy, 1'b0);
      chk("abort_rd_en", mem_rd_en, 1'b0);
      chk("abort_fill_valid", fill_valid, 1'b0);
      chk("abort_ready", miss_req_ready, 1'b1);
      @(negedge clk);
      mem_data_valid = 1'b0;
      chk("late_busy", busy, 1'b0);
      chk("late_fill_valid", fill_valid, 1'b0);
      chk("late_line", fill_line, 256'h0);
      req(vw.addr);
      serve(vw);
      handshake(vw);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
